// File: rtl/uart_pkg.sv
// UART shared definitions: parity codes, TX FSM states
// and a constant clog2 helper used by TX and RX blocks.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered count and
// combinational read of the head entry.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [clog2(DEPTH):0] count_o
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("sync_fifo DEPTH must be a power of 2 >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-fed UART transmitter with configurable frame
// format and runtime baud divisor; frames go out back to back.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_valid,
  input  logic [DATA_BITS-1:0]       s_data,
  output logic                       s_ready,
  input  logic [DIV_W-1:0]           baud_div,
  output logic                       tx_serial,
  output logic                       tx_busy,
  output logic [clog2(FIFO_DEPTH):0] fifo_count
);

  localparam logic [DIV_W-1:0] DEF_DIV =
    DIV_W'(CLK_FREQ / BAUD_RATE);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end

  tx_state_e            state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [DIV_W-1:0]     baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic [DATA_BITS-1:0] head;
  logic                 pop;
  logic                 load;
  logic                 full;
  logic                 empty;
  logic                 bit_end;

  sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (s_valid),
    .wdata_i(s_data),
    .pop_i  (pop),
    .rdata_o(head),
    .full_o (full),
    .empty_o(empty),
    .count_o(fifo_count)
  );

  assign s_ready   = !full;
  assign tx_serial = tx_q;
  assign tx_busy   = busy_q;
  assign bit_end   = (baud_q == div_q - 1'b1);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    load    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        load   = !empty;
      end
      ST_START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == LAST_DATA) begin
            bit_d = '0;
            if (PARITY != PAR_NONE) begin
              tx_d    = par_q;
              state_d = ST_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = ST_STOP;
            end
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == LAST_STOP) begin
            load = !empty;
            if (empty) begin
              tx_d    = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Frame start shared by IDLE and the zero-gap stop exit.
    if (load) begin
      pop     = 1'b1;
      div_d   = (baud_div == '0) ? DEF_DIV : baud_div;
      shift_d = head;
      par_d   = (PARITY == PAR_ODD) ? ~^head : ^head;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
      baud_d  = '0;
      state_d = ST_START;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      div_q   <= DEF_DIV;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: three frame formats
// (8N1, 8E1, 8O2), each with its own serial-line monitor.
module tb_uart_tx_fifo;

  typedef struct {
    logic [7:0] d;
    int         div;
    int         t0;
    bit         b2b;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] baud_div;
  logic        sv   [3];
  logic [7:0]  sd   [3];
  logic        srdy [3];
  logic        tx   [3];
  logic        busy [3];
  logic [4:0]  cnt  [3];
  exp_t        expq [3][$];

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int stall_cnt = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int PAR = g;
    localparam int STP = (g == 2) ? 2 : 1;
    localparam int NB  = 9 + ((PAR != 0) ? 1 : 0) + STP;

    uart_tx_fifo #(
      .DATA_BITS (8),
      .PARITY    (PAR),
      .STOP_BITS (STP),
      .FIFO_DEPTH(16),
      .DIV_W     (16)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .s_valid   (sv[g]),
      .s_data    (sd[g]),
      .s_ready   (srdy[g]),
      .baud_div  (baud_div),
      .tx_serial (tx[g]),
      .tx_busy   (busy[g]),
      .fifo_count(cnt[g])
    );

    initial begin : mon
      exp_t       e;
      logic [11:0] bits;
      int         last_end;
      int         c0;
      bit         abort;
      bit         okb;
      bit         okbusy;
      last_end = -100;
      forever begin
        @(negedge clk);
        if (!reset && tx[g] === 1'b0) begin
          c0 = cyc;
          if (expq[g].size() == 0) begin
            chk($sformatf("u%0d_unexpected_frame", g), 1, 0);
            for (int k = 0; k < 20000 && tx[g] !== 1'b1; k++)
              @(negedge clk);
          end else begin
            e = expq[g].pop_front();
            bits = '1;
            bits[0] = 1'b0;
            bits[8:1] = e.d;
            if (PAR == 1) bits[9] = ^e.d;
            if (PAR == 2) bits[9] = ~^e.d;
            okb = 1'b1;
            okbusy = 1'b1;
            abort = 1'b0;
            for (int k = 0; k < NB && !abort; k++) begin
              for (int j = 0; j < e.div && !abort; j++) begin
                if (k != 0 || j != 0) @(negedge clk);
                if (reset) abort = 1'b1;
                else begin
                  if (tx[g] !== bits[k]) okb = 1'b0;
                  if (busy[g] !== 1'b1) okbusy = 1'b0;
                end
              end
            end
            if (!abort) begin
              chk($sformatf("u%0d_frame_%02h", g, e.d), okb, 1);
              chk($sformatf("u%0d_busy_%02h", g, e.d), okbusy, 1);
              if (e.t0 >= 0)
                chk($sformatf("u%0d_start_cyc_%02h", g, e.d), c0, e.t0);
              if (e.b2b)
                chk($sformatf("u%0d_gap_%02h", g, e.d),
                    c0 - last_end - 1, 0);
              last_end = cyc;
            end
          end
        end
      end
    end
  end

  task automatic wr(input int i, input logic [7:0] d, input int div,
                    input bit b2b, input bit tchk, output int acc);
    exp_t e;
    int to;
    to = 0;
    sv[i] = 1'b1;
    sd[i] = d;
    while (srdy[i] !== 1'b1 && to < 2000) begin
      if (stall_cnt < 0) stall_cnt = int'(cnt[i]);
      @(negedge clk);
      to++;
    end
    if (to >= 2000) begin
      chk("wr_ready_timeout", 0, 1);
      acc = -1;
    end else begin
      acc = cyc + 1;
      e.d = d;
      e.div = div;
      e.t0 = tchk ? acc + 1 : -1;
      e.b2b = b2b;
      expq[i].push_back(e);
      @(negedge clk);
    end
  endtask

  task automatic idle(input int i);
    sv[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    int to;
    to = 0;
    while ((expq[i].size() != 0 || busy[i] !== 1'b0) && to < 30000) begin
      @(negedge clk);
      to++;
    end
    chk($sformatf("u%0d_drain", i), (to < 30000) ? 1 : 0, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation exceeded 60000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int a0;
    int nb;
    int to;
    logic [7:0] v;
    reset = 1'b1;
    baud_div = 16'd4;
    for (int i = 0; i < 3; i++) begin
      sv[i] = 1'b0;
      sd[i] = 8'h00;
    end
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d_rst_tx", i), tx[i], 1);
      chk($sformatf("u%0d_rst_busy", i), busy[i], 0);
      chk($sformatf("u%0d_rst_ready", i), srdy[i], 1);
      chk($sformatf("u%0d_rst_count", i), cnt[i], 0);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);

    wr(0, 8'hA5, 4, 1'b0, 1'b1, acc);
    idle(0);
    nb = 0;
    to = 0;
    while (busy[0] !== 1'b1 && to < 10) begin
      @(negedge clk);
      to++;
    end
    while (busy[0] === 1'b1 && nb < 100) begin
      nb++;
      @(negedge clk);
    end
    chk("8n1_busy_len", nb, 40);
    drain(0);

    wr(1, 8'h07, 4, 1'b0, 1'b1, acc);
    idle(1);
    while (cyc < acc + 38) @(negedge clk);
    chk("8e1_parity_07", tx[1], 1);
    drain(1);

    wr(2, 8'h07, 4, 1'b0, 1'b1, acc);
    idle(2);
    while (cyc < acc + 38) @(negedge clk);
    chk("8o2_parity_07", tx[2], 0);
    while (cyc < acc + 48) @(negedge clk);
    chk("8o2_stop2_line", tx[2], 1);
    chk("8o2_stop2_busy", busy[2], 1);
    @(negedge clk);
    chk("8o2_busy_end", busy[2], 0);
    drain(2);

    stall_cnt = -1;
    wr(0, 8'h10, 4, 1'b0, 1'b1, acc);
    for (int n = 1; n < 20; n++) begin
      v = 8'(n * 37 + 11);
      wr(0, v, 4, 1'b1, 1'b0, acc);
    end
    idle(0);
    chk("burst_stall_count", stall_cnt, 16);
    drain(0);

    wr(0, 8'h5A, 4, 1'b0, 1'b1, acc);
    wr(0, 8'hC3, 8, 1'b1, 1'b0, acc);
    idle(0);
    repeat (10) @(negedge clk);
    baud_div = 16'd8;
    drain(0);
    baud_div = 16'd0;
    wr(0, 8'h96, 868, 1'b0, 1'b1, acc);
    idle(0);
    drain(0);
    baud_div = 16'd4;

    wr(0, 8'hA5, 4, 1'b0, 1'b1, a0);
    wr(0, 8'h11, 4, 1'b1, 1'b0, acc);
    wr(0, 8'h22, 4, 1'b1, 1'b0, acc);
    wr(0, 8'h33, 4, 1'b1, 1'b0, acc);
    idle(0);
    while (cyc < a0 + 18) @(negedge clk);
    chk("pre_reset_bit3", tx[0], 0);
    chk("pre_reset_count", cnt[0], 3);
    #1;
    reset = 1'b1;
    expq[0].delete();
    #1;
    chk("rst_mid_tx", tx[0], 1);
    chk("rst_mid_busy", busy[0], 0);
    chk("rst_mid_count", cnt[0], 0);
    chk("rst_mid_ready", srdy[0], 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    wr(0, 8'h3C, 4, 1'b0, 1'b1, acc);
    idle(0);
    drain(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
